// File: rtl/decode_hazard_unit.sv
// ID-stage decoder for the extended MIPS subset with Tuse/Tnew hazard tracking
// over the E and M entries and the mult/div busy counter; produces the D stall.
module decode_hazard_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      i_instr_id,
    input  logic             i_id_valid,
    output logic [4:0]       o_a1,
    output logic [4:0]       o_a2,
    output logic [4:0]       o_a3,
    output logic             o_stall,
    output logic [4:0]       o_e_a3,
    output logic [4:0]       o_m_a3,
    output logic [1:0]       o_e_tnew,
    output logic [1:0]       o_m_tnew,
    output logic             o_md_busy,
    output logic [CNT_W-1:0] o_md_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Field extraction
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unused_shamt;

    assign w_op           = i_instr_id[31:26];
    assign w_funct        = i_instr_id[5:0];
    assign w_rs           = i_instr_id[25:21];
    assign w_rt           = i_instr_id[20:16];
    assign w_rd           = i_instr_id[15:11];
    assign w_unused_shamt = ^i_instr_id[10:6];

    // Decoded D-stage attributes
    logic       w_rs_rd;
    logic [1:0] w_rs_tuse;
    logic       w_rt_rd;
    logic [1:0] w_rt_tuse;
    logic [4:0] w_a3_dec;
    logic [1:0] w_tnew_dec;
    logic       w_md_op;
    logic       w_md_div;
    logic       w_md_any;

    always_comb begin
        w_rs_rd    = 1'b0;
        w_rs_tuse  = 2'd0;
        w_rt_rd    = 1'b0;
        w_rt_tuse  = 2'd0;
        w_a3_dec   = 5'd0;
        w_tnew_dec = 2'd0;
        w_md_op    = 1'b0;
        w_md_div   = 1'b0;
        w_md_any   = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADDU, FN_SUBU, FN_SLT: begin
                        w_rs_rd    = 1'b1;
                        w_rs_tuse  = 2'd1;
                        w_rt_rd    = 1'b1;
                        w_rt_tuse  = 2'd1;
                        w_a3_dec   = w_rd;
                        w_tnew_dec = 2'd1;
                    end
                    FN_JR: begin
                        w_rs_rd   = 1'b1;
                        w_rs_tuse = 2'd0;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        w_rs_rd   = 1'b1;
                        w_rs_tuse = 2'd1;
                        w_rt_rd   = 1'b1;
                        w_rt_tuse = 2'd1;
                        w_md_op   = 1'b1;
                        w_md_div  = (w_funct == FN_DIV) || (w_funct == FN_DIVU);
                        w_md_any  = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        w_a3_dec   = w_rd;
                        w_tnew_dec = 2'd1;
                        w_md_any   = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        w_rs_rd   = 1'b1;
                        w_rs_tuse = 2'd1;
                        w_md_any  = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ORI: begin
                w_rs_rd    = 1'b1;
                w_rs_tuse  = 2'd1;
                w_a3_dec   = w_rt;
                w_tnew_dec = 2'd1;
            end
            OP_LUI: begin
                w_a3_dec   = w_rt;
                w_tnew_dec = 2'd1;
            end
            OP_LW: begin
                w_rs_rd    = 1'b1;
                w_rs_tuse  = 2'd1;
                w_a3_dec   = w_rt;
                w_tnew_dec = 2'd2;
            end
            OP_SW: begin
                // store data is needed only in M, hence the later Tuse on rt
                w_rs_rd   = 1'b1;
                w_rs_tuse = 2'd1;
                w_rt_rd   = 1'b1;
                w_rt_tuse = 2'd2;
            end
            OP_BEQ: begin
                w_rs_rd   = 1'b1;
                w_rs_tuse = 2'd0;
                w_rt_rd   = 1'b1;
                w_rt_tuse = 2'd0;
            end
            OP_JAL: begin
                w_a3_dec   = 5'd31;
                w_tnew_dec = 2'd0;
            end
            OP_J:    ;
            default: ;
        endcase
    end

    // Pipeline entries
    logic [4:0]       r_e_a3;
    logic [1:0]       r_e_tnew;
    logic             r_e_md_start;
    logic             r_e_md_div;
    logic [4:0]       r_m_a3;
    logic [1:0]       r_m_tnew;
    logic [CNT_W-1:0] r_md_count;

    // Hazard comparison against each in-flight writer (0 = E, 1 = M)
    logic [4:0] w_x_a3   [2];
    logic [1:0] w_x_tnew [2];
    logic [1:0] w_x_hit;

    assign w_x_a3[0]   = r_e_a3;
    assign w_x_tnew[0] = r_e_tnew;
    assign w_x_a3[1]   = r_m_a3;
    assign w_x_tnew[1] = r_m_tnew;

    for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
        logic w_rs_hit;
        logic w_rt_hit;
        assign w_rs_hit = w_rs_rd && (w_x_a3[gi] == w_rs) && (w_x_tnew[gi] > w_rs_tuse);
        assign w_rt_hit = w_rt_rd && (w_x_a3[gi] == w_rt) && (w_x_tnew[gi] > w_rt_tuse);
        assign w_x_hit[gi] = (w_x_a3[gi] != 5'd0) && (w_rs_hit || w_rt_hit);
    end

    logic w_md_busy;
    logic w_data_stall;
    logic w_md_stall;
    logic w_stall;
    logic w_issue;
    logic [4:0] w_a3;

    assign w_md_busy    = r_e_md_start || (r_md_count != '0);
    assign w_data_stall = |w_x_hit;
    assign w_md_stall   = w_md_any && w_md_busy;
    assign w_stall      = i_id_valid && (w_data_stall || w_md_stall);
    assign w_issue      = i_id_valid && !w_stall;
    assign w_a3         = i_id_valid ? w_a3_dec : 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_a3       <= 5'd0;
            r_e_tnew     <= 2'd0;
            r_e_md_start <= 1'b0;
            r_e_md_div   <= 1'b0;
            r_m_a3       <= 5'd0;
            r_m_tnew     <= 2'd0;
        end else begin
            if (w_issue) begin
                r_e_a3       <= w_a3_dec;
                r_e_tnew     <= w_tnew_dec;
                r_e_md_start <= w_md_op;
                r_e_md_div   <= w_md_div;
            end else begin
                r_e_a3       <= 5'd0;
                r_e_tnew     <= 2'd0;
                r_e_md_start <= 1'b0;
                r_e_md_div   <= 1'b0;
            end
            r_m_a3   <= r_e_a3;
            r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
        end
    end

    // A start in E always reloads, even if a countdown is still running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_count <= '0;
        end else if (r_e_md_start) begin
            r_md_count <= r_e_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (r_md_count != '0) begin
            r_md_count <= r_md_count - CNT_ONE;
        end
    end

    assign o_a1       = w_rs;
    assign o_a2       = w_rt;
    assign o_a3       = w_a3;
    assign o_stall    = w_stall;
    assign o_e_a3     = r_e_a3;
    assign o_m_a3     = r_m_a3;
    assign o_e_tnew   = r_e_tnew;
    assign o_m_tnew   = r_m_tnew;
    assign o_md_busy  = w_md_busy;
    assign o_md_count = r_md_count;

endmodule

// File: doc/decode_hazard_unit.md
# decode_hazard_unit

Parametrised ID-stage decoder with hazard tracking for the five-stage MIPS pipeline. Decodes the extended instruction set (base ALU/memory/branch/jump ops plus mult/div and HI/LO moves), derives register addresses and Tuse/Tnew timing, and tracks in-flight writers in E and M. Outputs a D-stage stall. It also owns the mult/div busy counter, so the controller needs no separate stall logic.

## Interface
- MULT_CYCLES, 5: busy cycles after mult/multu leaves E.
- DIV_CYCLES, 10: busy cycles after div/divu leaves E.
- CNT_W, 4: busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_id  in  32  instruction in D.
- id_valid  in  1  instr_id is a real instruction; 0 = bubble.
- a1, a2  out  5  instr_id[25:21], instr_id[20:16], unconditionally.
- a3  out  5  D-stage write register (combinational).
- stall  out  1  hold F/D, insert bubble into E.
- e_a3, m_a3  out  5  write register held in E / M entry (0 when empty).
- e_tnew, m_tnew  out  2  cycles until E / M result is available.
- md_busy  out  1  mult/div unit busy or starting.
- md_count  out  CNT_W  remaining busy cycles.

## Operation
- Decode, op = [31:26], funct = [5:0]:
  - R-type (op 0): addu 100001, subu 100011, slt 101010, jr 001000, mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010, mthi 010001, mtlo 010011.
  - I/J: addi 001000, addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - Anything else is a nop: no reads, a3 = 0.
- a3 by instruction:
  - rd for addu/subu/slt/mfhi/mflo.
  - rt for addi/addiu/ori/lui/lw.
  - 31 for jal.
  - 0 otherwise, or when id_valid = 0.
- Tuse:
  - 0: beq rs/rt, jr rs.
  - 1: ALU rs and R-type rt, lw/sw rs, mult/div rs/rt, mthi/mtlo rs.
  - 2: sw rt.
  - No read: lui, j, jal, mfhi, mflo.
- Tnew entering E: lw 2; ALU ops, mfhi, mflo 1; jal 0.
- Entries: E and M, each {a3, tnew, md_start}. No W entry; W results reach D by register-file write-through and never stall.
- Each edge, not stalled:
  - E ← decoded D instruction, or empty if id_valid = 0.
  - M ← E with tnew = max(tnew − 1, 0).
- Each edge, stalled: E ← empty; M advances as above.
- Data stall, for X in {E, M}: a3_X ≠ 0, a3_X equals a source D reads, and tnew_X > Tuse of that source. Register 0 never stalls.
- md_start = E holds mult/multu/div/divu.
- Busy counter, each edge:
  - md_start: load MULT_CYCLES or DIV_CYCLES.
  - Else if md_count ≠ 0: decrement by 1.
- md_busy = md_start | (md_count ≠ 0).
- MD stall: D holds any mult/div/mfhi/mflo/mthi/mtlo while md_busy.
- stall = id_valid & (data stall | MD stall).

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately):
  - E and M empty; e_a3 = m_a3 = 0, e_tnew = m_tnew = 0.
  - md_count = 0, md_busy = 0, hence stall = 0.
  - Reset during an active stall or countdown aborts both; no residue after release.
- Decode outputs and stall are combinational from instr_id and state, in the same cycle. Entry registers have 1-cycle latency.
- Load-use: lw then dependent ALU op gives exactly 1 bubble. lw then beq/jr on its rt gives 2 bubbles.
- ALU op then beq/jr on its result gives 1 bubble.
- mult then mflo: 1 + MULT_CYCLES stall cycles. div: 1 + DIV_CYCLES.
- Non-MD instructions issue freely while md_busy.
- A new mult entering E while md_count ≠ 0 cannot occur, because the MD stall prevents it. If it is forced, the counter reloads.
- Data and MD stall may both be true; stall is a single OR, and bubbles are not double-counted.

## Test plan
- Reset: hold lw $8 in E and md_count = 7, pull rst_n low mid-cycle → e_a3 = 0, md_count = 0, stall = 0 before the next edge.
- lw $8,0($1); addu $9,$8,$10 → stall = 1 for exactly 1 cycle (e_tnew = 2), then stall = 0 with m_a3 = 8, m_tnew = 1; e_a3 = 0 during the bubble.
- addu $8,$1,$2; beq $8,$9 → 1-cycle stall. lw $8; beq $8,$0 → 2 stall cycles.
- lw $8; sw $8,0($9) → no stall. lw $8; sw $9,0($8) → 1-cycle stall.
- mult $4,$5; mflo $6 with MULT_CYCLES = 5 → stall held 6 cycles, md_count sequence 5,4,3,2,1,0. div with DIV_CYCLES = 10 → 11 cycles. addu in D during busy → no stall.
- addu $0,$1,$2; addu $9,$0,$0 → no stall. id_valid = 0 with a hazard-matching instr_id → stall = 0, E empty next cycle.
